// File: rtl/mul_pkg.sv
// mul_pkg: shared FSM state type and sizing constants for the sequential Booth multiplier.
package mul_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} mul_state_t;
  localparam int MUL_ITER = 16;
  localparam int CNT_W = 4;
endpackage

// File: rtl/addsub_16bit.sv
// addsub_16bit: 16-bit adder/subtractor; overflow is the unsigned carry (add) or borrow (sub).
module addsub_16bit (
  input  logic [15:0] A,
  input  logic [15:0] B,
  input  logic        sub,
  output logic [15:0] Sum,
  output logic        overflow
);
  logic [16:0] r;
  assign r = {1'b0, A} + {1'b0, B ^ {16{sub}}} + 17'(sub);
  assign Sum = r[15:0];
  assign overflow = r[16] ^ sub;
endmodule

// File: rtl/booth_mul_seq.sv
// booth_mul_seq: signed 16x16 radix-2 Booth multiplier, one add/sub-and-shift step per cycle.
module booth_mul_seq
  import mul_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] mcand,
  input  logic [15:0] mplier,
  output logic        ready,
  output logic        busy,
  output logic        done,
  output logic [31:0] product
);
  mul_state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [15:0] m_q, m_d, acc_q, acc_d, q_q, q_d;
  logic q1_q, q1_d;
  logic [31:0] product_q, product_d;
  logic add_en, sub, sv, nsign, last, carry_unused;
  logic [15:0] sum, nacc, step_acc, step_q;
  addsub_16bit u_addsub (
    .A(acc_q),
    .B(m_q),
    .sub(sub),
    .Sum(sum),
    .overflow(carry_unused)
  );
  assign add_en = q_q[0] ^ q1_q;
  assign sub = q_q[0];
  // Signed overflow means Sum[15] is not the true 17-bit sign; flip it so M=0x8000 shifts correctly.
  assign sv = (acc_q[15] == (m_q[15] ^ sub)) && (sum[15] != acc_q[15]);
  assign nacc = add_en ? sum : acc_q;
  assign nsign = add_en ? sum[15] ^ sv : acc_q[15];
  assign step_acc = {nsign, nacc[15:1]};
  assign step_q = {nacc[0], q_q[15:1]};
  assign last = cnt_q == CNT_W'(MUL_ITER - 1);
  assign ready = state_q != RUN;
  assign busy = state_q == RUN;
  assign done = state_q == DONE;
  assign product = product_q;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    m_d = m_q;
    acc_d = acc_q;
    q_d = q_q;
    q1_d = q1_q;
    product_d = product_q;
    if (ready && start) begin
      state_d = RUN;
      m_d = mcand;
      acc_d = '0;
      q_d = mplier;
      q1_d = 1'b0;
      cnt_d = '0;
    end else if (state_q == RUN) begin
      acc_d = step_acc;
      q_d = step_q;
      q1_d = q_q[0];
      cnt_d = cnt_q + 1'b1;
      if (last) begin
        state_d = DONE;
        product_d = {step_acc, step_q};
      end
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      m_q <= '0;
      acc_q <= '0;
      q_q <= '0;
      q1_q <= 1'b0;
      product_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      m_q <= m_d;
      acc_q <= acc_d;
      q_q <= q_d;
      q1_q <= q1_d;
      product_q <= product_d;
    end
  end
endmodule

// File: tb/tb_booth_mul_seq.sv
// tb_booth_mul_seq: directed and random checks of booth_mul_seq against integer multiplication.
module tb_booth_mul_seq;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [15:0] mcand = '0, mplier = '0;
  logic ready, busy, done;
  logic [31:0] product;
  int total = 0, bad = 0;
  booth_mul_seq dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .mcand(mcand),
    .mplier(mplier),
    .ready(ready),
    .busy(busy),
    .done(done),
    .product(product)
  );
  always #5 clk = ~clk;
  function automatic logic [31:0] ref_mul(input logic [15:0] a, input logic [15:0] b);
    int sa, sb;
    sa = $signed(a);
    sb = $signed(b);
    return 32'(sa * sb);
  endfunction
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask
  task automatic start_op(input logic [15:0] a, input logic [15:0] b);
    @(negedge clk);
    mcand = a;
    mplier = b;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask
  task automatic wait_done(input string tag, input logic [15:0] a, input logic [15:0] b, input int lat);
    int n = 0;
    while (done !== 1'b1 && n < 40) begin
      @(posedge clk);
      #1 n++;
    end
    check({tag, "_lat"}, 32'(n), 32'(lat));
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_prod"}, product, ref_mul(a, b));
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_prod", product, 32'd0);
    rst = 1'b0;
    start_op(16'h0003, 16'h0005);
    check("b1_busy", 32'(busy), 32'd1);
    check("b1_ready", 32'(ready), 32'd0);
    wait_done("3x5", 16'h0003, 16'h0005, 16);
    check("3x5_const", product, 32'h0000000F);
    @(posedge clk);
    #1;
    check("3x5_pulse", 32'(done), 32'd0);
    check("3x5_idle", 32'(ready), 32'd1);
    check("3x5_hold", product, 32'h0000000F);
    start_op(16'hFFF9, 16'h0006);
    wait_done("m7x6", 16'hFFF9, 16'h0006, 16);
    check("m7x6_const", product, 32'hFFFFFFD6);
    start_op(16'h7FFF, 16'h7FFF);
    wait_done("maxpos", 16'h7FFF, 16'h7FFF, 16);
    check("maxpos_const", product, 32'h3FFF0001);
    start_op(16'h8000, 16'h8000);
    wait_done("negneg", 16'h8000, 16'h8000, 16);
    check("negneg_const", product, 32'h40000000);
    start_op(16'h8000, 16'h0001);
    wait_done("negx1", 16'h8000, 16'h0001, 16);
    check("negx1_const", product, 32'hFFFF8000);
    start_op(16'h0002, 16'h0003);
    repeat (5) @(posedge clk);
    @(negedge clk);
    mcand = 16'h0007;
    mplier = 16'h0009;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    check("mid_busy", 32'(busy), 32'd1);
    wait_done("mid", 16'h0002, 16'h0003, 10);
    start_op(16'h1234, 16'h0777);
    repeat (8) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_done", 32'(done), 32'd0);
    check("arst_prod", product, 32'd0);
    check("arst_ready", 32'(ready), 32'd1);
    @(posedge clk);
    #1 rst = 1'b0;
    start_op(16'h0002, 16'h0002);
    wait_done("post_rst", 16'h0002, 16'h0002, 16);
    start_op(16'h1234, 16'h0010);
    wait_done("b2b_a", 16'h1234, 16'h0010, 16);
    mcand = 16'hFFFF;
    mplier = 16'hFFFF;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    check("b2b_busy", 32'(busy), 32'd1);
    check("b2b_ndone", 32'(done), 32'd0);
    wait_done("b2b_b", 16'hFFFF, 16'hFFFF, 16);
    for (int i = 0; i < 24; i++) begin
      logic [15:0] a, b;
      a = 16'($urandom);
      b = 16'($urandom);
      start_op(a, b);
      wait_done("rand", a, b, 16);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
